if_fetch_seq: RTL
=================

IF_FETCH_SEQ -- requirements
Module: if_fetch_seq

Interface
REQ-001 SHALL have parameter RESET_PC, default 16'h0000: fetch address after reset.
REQ-002 SHALL have parameter BUF_DEPTH, default 2: instruction buffer entries (legal 2..4).
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port imem_req  output  1  fetch request to instruction memory.
REQ-006 SHALL have port imem_addr  output  16  word address of the request.
REQ-007 SHALL have port imem_gnt  input  1  request accepted this cycle.
REQ-008 SHALL have port imem_rvalid  input  1  read data valid, at least 1 cycle after grant.
REQ-009 SHALL have port imem_rdata  input  16  fetched instruction word.
REQ-010 SHALL have port redir_valid  input  1  branch/jump redirect from execute.
REQ-011 SHALL have port redir_pc  input  16  redirect target (PC + 1 + offset, computed in EX).
REQ-012 SHALL have port instr_valid  output  1  buffer head valid.
REQ-013 SHALL have port instr_ready  input  1  decode accepts head.
REQ-014 SHALL have port instr  output  16  head instruction word.
REQ-015 SHALL have port instr_pc  output  16  address of the head instruction.

Function
REQ-016 SHALL implement states FETCH, WAIT, KILL, HALT.
REQ-017 SHALL, in FETCH, drive imem_req=1 and imem_addr=pc only when buffered count < BUF_DEPTH; else imem_req=0.
REQ-018 SHALL, on imem_req & imem_gnt, latch req_pc<=pc, pc<=pc+1 (16-bit wrap, 16'hFFFF->16'h0000), move to WAIT; at most one request outstanding.
REQ-019 SHALL, in WAIT on imem_rvalid, push {req_pc, imem_rdata} to the buffer and return to FETCH; imem_req=0 throughout WAIT and KILL.
REQ-020 SHALL present the buffer head combinationally on instr/instr_pc with instr_valid = not empty; pop on instr_valid & instr_ready.
REQ-021 SHALL allow push and pop in the same cycle; overflow is impossible by REQ-017.
REQ-022 SHALL, on redir_valid in any state: set pc<=redir_pc, flush all buffer entries at that edge, complete any head transfer handshaken in that same cycle, and ignore imem_gnt/rvalid for data retention that cycle.
REQ-023 SHALL, on redirect in WAIT without same-cycle imem_rvalid, go to KILL, discard the next imem_rvalid, then go to FETCH.
REQ-024 SHALL, on redirect in WAIT with same-cycle imem_rvalid, discard that data and go to FETCH.
REQ-025 SHALL, on redirect in FETCH coinciding with imem_gnt, go to KILL (stale request) with pc<=redir_pc.
REQ-026 SHALL assert imem_req with redir_pc no earlier than the cycle after the redirect.

Reset
REQ-027 SHALL asynchronously on rst_n=0 set pc=RESET_PC, state FETCH, buffer empty, imem_req=0, instr_valid=0, discarding any outstanding request.
REQ-028 SHALL assert imem_req with imem_addr=RESET_PC in the first cycle after rst_n deasserts.

Configuration
REQ-029 SHALL, with IF_HALT_STOP_EN defined, enter HALT when an entry with opcode 4'hF is pushed, issue no further requests, keep draining the buffer, and leave HALT only on redir_valid (to FETCH).
REQ-030 SHALL, without IF_HALT_STOP_EN, treat opcode 4'hF as an ordinary instruction and never enter HALT.

Structure
REQ-031 SHALL place opcode constants (OP_BR=4'hC, OP_HALT=4'hF), state encoding and the {pc, instr} entry type in shared package if_pkg.
REQ-032 SHALL implement the buffer as sub-module if_fetch_buf (synchronous FIFO, flush input).

Verification
REQ-033 SHALL cover reset release with RESET_PC=16'h0010, gnt same cycle, rvalid next -> head instr_pc=16'h0010, next imem_addr=16'h0011.
REQ-034 SHALL cover instr_ready=0 for 10 cycles -> exactly BUF_DEPTH entries buffered, imem_req=0, no data lost on release.
REQ-035 SHALL cover redir_valid with redir_pc=16'h0042 one cycle before rvalid -> that response dropped, next imem_addr=16'h0042, no stale instr_valid.
REQ-036 SHALL cover pc=16'hFFFF granted -> next imem_addr=16'h0000.
REQ-037 SHALL cover fetch of 16'hF000 with IF_HALT_STOP_EN -> imem_req stays 0 until redirect to 16'h0100, then fetch resumes at 16'h0100.

Source files
------------

// File: rtl/if_pkg.sv
// Shared types and constants for the instruction fetch sequencer: opcodes,
// FSM state encoding and the {pc, instr} buffer entry.
package if_pkg;

    localparam logic [3:0] OP_BR   = 4'hC;
    localparam logic [3:0] OP_HALT = 4'hF;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        KILL  = 2'd2,
        HALT  = 2'd3
    } fetch_state_e;

    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] instr;
    } fetch_entry_t;

    function automatic logic [3:0] opcode_of(input logic [15:0] word);
        return word[15:12];
    endfunction

endpackage

// File: rtl/if_fetch_buf.sv
// Small synchronous FIFO of fetched {pc, instr} entries with a single-cycle
// flush; the head entry is visible combinationally.
module if_fetch_buf
    import if_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t wr_entry,
    output fetch_entry_t head,
    output logic         empty,
    output logic         full
);

    localparam int PW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    fetch_entry_t  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count_q;
    logic          do_push;
    logic          do_pop;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= wr_entry;
    end

endmodule

// File: rtl/if_fetch_seq.sv
// Instruction fetch sequencer: one outstanding imem request, redirect/kill
// handling and a small instruction buffer. Optional HALT stop: IF_HALT_STOP_EN.
module if_fetch_seq
    import if_pkg::*;
#(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    output logic         imem_req,
    output logic [15:0]  imem_addr,
    input  logic         imem_gnt,
    input  logic         imem_rvalid,
    input  logic [15:0]  imem_rdata,
    input  logic         redir_valid,
    input  logic [15:0]  redir_pc,
    output logic         instr_valid,
    input  logic         instr_ready,
    output logic [15:0]  instr,
    output logic [15:0]  instr_pc,
    output fetch_state_e dbg_state
);

`ifdef IF_HALT_STOP_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    // Handshakes: a transfer happens on a rising edge where valid (imem_req,
    // instr_valid) and ready (imem_gnt, instr_ready) are both high; valid never
    // depends combinationally on ready.
    fetch_state_e state_q, state_d;
    logic [15:0]  pc_q, pc_d;
    logic [15:0]  req_pc_q, req_pc_d;
    logic         push;
    logic         pop;
    logic         buf_full;
    logic         buf_empty;
    logic         halt_hit;
    fetch_entry_t head;

    assign halt_hit = HALT_EN && (opcode_of(imem_rdata) == OP_HALT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= FETCH;
            pc_q     <= RESET_PC;
            req_pc_q <= RESET_PC;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        req_pc_d = req_pc_q;
        push     = 1'b0;
        imem_req = 1'b0;
        case (state_q)
            FETCH: begin
                imem_req = rst_n & ~buf_full;
                if (imem_req && imem_gnt) begin
                    req_pc_d = pc_q;
                    pc_d     = pc_q + 16'd1;
                    // A redirect in the grant cycle leaves a stale response in flight.
                    state_d  = redir_valid ? KILL : WAIT;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    push    = ~redir_valid;
                    state_d = (!redir_valid && halt_hit) ? HALT : FETCH;
                end else if (redir_valid) begin
                    state_d = KILL;
                end
            end
            KILL: begin
                if (imem_rvalid) state_d = FETCH;
            end
            HALT: begin
                if (redir_valid) state_d = FETCH;
            end
            default: state_d = FETCH;
        endcase
        if (redir_valid) pc_d = redir_pc;
    end

    assign imem_addr = pc_q;
    assign pop       = instr_valid & instr_ready;

    if_fetch_buf #(
        .DEPTH (BUF_DEPTH)
    ) u_buf (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .pop      (pop),
        .flush    (redir_valid),
        .wr_entry ('{pc: req_pc_q, instr: imem_rdata}),
        .head     (head),
        .empty    (buf_empty),
        .full     (buf_full)
    );

    assign instr_valid = ~buf_empty;
    assign instr       = head.instr;
    assign instr_pc    = head.pc;
    assign dbg_state   = state_q;

endmodule
